// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the data-memory responder:
//   DATA_W / ADDR_W : width of a memory word and of a byte address
//   state_t         : responder FSM states (IDLE, WAIT, RESP)
//   op_t            : captured request kind (OP_LOAD, OP_STORE)
// -----------------------------------------------------------------------------
package data_mem_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_t;

endpackage

// File: rtl/data_mem_array.sv
// -----------------------------------------------------------------------------
// data_mem_array
// DEPTH x DATA_W single-port storage, synchronous write and synchronous read.
// The read register only updates on a read, so it holds the last load result.
// Contents are never reset; only the read register is.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (read register only)
//   i_we     write strobe
//   i_re     read strobe (never asserted together with i_we)
//   i_addr   word index
//   i_wdata  write data
//   o_rdata  registered read data
// -----------------------------------------------------------------------------
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder of the load/store interface. A request is captured in
// IDLE, waits WAIT_STATES cycles, and completes on the edge entering RESP, when
// the store is committed or the load result is registered and MemReady pulses.
// Ports:
//   CLK        clock
//   Reset_n    asynchronous active-low reset
//   Address    byte address of the request
//   StoreData  data to store
//   MemRead    load request, held until MemReady
//   MemWrite   store request, held until MemReady (wins over MemRead)
//   ReadData   last load result, registered
//   MemReady   one-cycle completion pulse
//   MemError   (only with MEM_BOUNDS_CHECK_EN) misaligned / out-of-range flag,
//              pulsed with MemReady; the access itself is suppressed
// Optional feature macro: MEM_BOUNDS_CHECK_EN
// -----------------------------------------------------------------------------
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int ADDR_LSB    = 3,
    parameter int WAIT_STATES = 2
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] StoreData,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [DATA_W-1:0] ReadData,
`ifdef MEM_BOUNDS_CHECK_EN
    output logic              MemError,
`endif
    output logic              MemReady
);

    localparam int IDX_W     = $clog2(DEPTH);
    localparam int CNT_W     = 4;
    localparam bit ZERO_WAIT = (WAIT_STATES == 0);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_data;
    op_t                r_op;

    logic               w_req;
    logic               w_capture;
    logic               w_enter;
    logic               w_err;
    logic               w_we;
    logic               w_re;
    op_t                w_op_live;
    op_t                w_op;
    logic [IDX_W-1:0]   w_idx_live;
    logic [IDX_W-1:0]   w_idx;
    logic [DATA_W-1:0]  w_wdata;

    assign w_req      = MemRead | MemWrite;
    assign w_capture  = (r_state == IDLE) && w_req;
    assign w_op_live  = MemWrite ? OP_STORE : OP_LOAD;
    // Upper address bits are dropped, so the index wraps modulo DEPTH.
    assign w_idx_live = Address[ADDR_LSB +: IDX_W];

`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH) << ADDR_LSB;
    logic r_err;
    logic w_err_live;
    assign w_err_live = (|Address[ADDR_LSB-1:0]) || (Address >= LIMIT);
    assign w_err      = ZERO_WAIT ? w_err_live : r_err;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{Address[ADDR_LSB-1:0], Address[ADDR_W-1:ADDR_LSB+IDX_W]};
    assign w_err         = 1'b0;
`endif

    // With no wait states the capture edge is also the RESP-entry edge, so the
    // access must use the live request rather than the (not yet loaded) copy.
    assign w_enter = ZERO_WAIT ? w_capture : ((r_state == WAIT) && (r_cnt == '0));
    assign w_idx   = ZERO_WAIT ? w_idx_live : r_idx;
    assign w_wdata = ZERO_WAIT ? StoreData  : r_data;
    assign w_op    = ZERO_WAIT ? w_op_live  : r_op;

    assign w_we = w_enter && (w_op == OP_STORE) && !w_err;
    assign w_re = w_enter && (w_op == OP_LOAD)  && !w_err;

    always_ff @(posedge CLK) begin
        if (w_capture) begin
            r_idx  <= w_idx_live;
            r_data <= StoreData;
            r_op   <= w_op_live;
`ifdef MEM_BOUNDS_CHECK_EN
            r_err  <= w_err_live;
`endif
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            MemReady <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
            MemError <= 1'b0;
`endif
        end else begin
            MemReady <= w_enter;
`ifdef MEM_BOUNDS_CHECK_EN
            MemError <= w_enter && w_err;
`endif
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (ZERO_WAIT) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_W'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    data_mem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .i_clk  (CLK),
        .i_rst_n(Reset_n),
        .i_we   (w_we),
        .i_re   (w_re),
        .i_addr (w_idx),
        .i_wdata(w_wdata),
        .o_rdata(ReadData)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Two responders share clock and reset: instance 0 with WAIT_STATES=2 and
// instance 1 with WAIT_STATES=0. The driver issues one request at a time,
// pushing the expected response (data, error flag, completion cycle) computed
// from a word-array model; a monitor pops and compares on every MemReady.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    typedef struct {
        int          inst;
        logic [63:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic [63:0] addr  [2];
    logic [63:0] sdata [2];
    logic [63:0] rdata [2];
    logic        mrd   [2];
    logic        mwr   [2];
    logic        rdy   [2];
`ifdef MEM_BOUNDS_CHECK_EN
    logic        merr  [2];
`endif

    int          cyc = 0;
    int          ws_of [2] = '{2, 0};
    logic [63:0] mem_m [2][64];
    logic [63:0] rd_m  [2];
    bit          busy  [2];
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH(64), .ADDR_LSB(3), .WAIT_STATES(2)) u_dut0 (
        .CLK(CLK), .Reset_n(Reset_n), .Address(addr[0]), .StoreData(sdata[0]),
        .MemRead(mrd[0]), .MemWrite(mwr[0]), .ReadData(rdata[0]),
`ifdef MEM_BOUNDS_CHECK_EN
        .MemError(merr[0]),
`endif
        .MemReady(rdy[0])
    );

    data_mem_responder #(.DEPTH(64), .ADDR_LSB(3), .WAIT_STATES(0)) u_dut1 (
        .CLK(CLK), .Reset_n(Reset_n), .Address(addr[1]), .StoreData(sdata[1]),
        .MemRead(mrd[1]), .MemWrite(mwr[1]), .ReadData(rdata[1]),
`ifdef MEM_BOUNDS_CHECK_EN
        .MemError(merr[1]),
`endif
        .MemReady(rdy[1])
    );

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (Reset_n === 1'b1 && rdy[i] === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0 || exp_q[0].inst != i) begin
                    miscompares++;
                    $display("FAIL unexpected_ready inst=%0d cyc=%0d: MemReady=1, no request outstanding", i, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (rdata[i] !== mon_e.rdata || cyc != mon_e.due
`ifdef MEM_BOUNDS_CHECK_EN
                        || merr[i] !== mon_e.err
`endif
                       ) begin
                        miscompares++;
                        $display("FAIL response inst=%0d: ReadData=%h at cyc %0d err=%b, required %h at cyc %0d err=%b",
                                 i, rdata[i], cyc,
`ifdef MEM_BOUNDS_CHECK_EN
                                 merr[i],
`else
                                 1'b0,
`endif
                                 mon_e.rdata, mon_e.due, mon_e.err);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    function automatic logic [63:0] rand_addr();
        int          sel;
        logic [63:0] a;
        sel = $urandom_range(0, 9);
        if (sel < 7)      a = 64'($urandom_range(0, 63)) << 3;
        else if (sel < 9) a = {$urandom, $urandom};
        else              a = 64'($urandom_range(0, 511));
        return a;
    endfunction

    // Called at a negedge. Leaves the request asserted after the pulse so a
    // following call issues back-to-back; release_req() drops it instead.
    task automatic do_req(input int i, input bit wr, input bit rd,
                          input logic [63:0] a, input logic [63:0] d,
                          input bit pert, input logic [63:0] alt);
        exp_t e;
        int   cap;
        int   idx;
        bit   err;
        bit   got;
        idx = int'((a / 64'd8) % 64'd64);
        err = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
        err = ((a % 64'd8) != 64'd0) || (a >= 64'd512);
`endif
        if (wr) begin
            if (!err) mem_m[i][idx] = d;
        end else if (!err) begin
            rd_m[i] = mem_m[i][idx];
        end
        cap    = cyc + (busy[i] ? 2 : 1);
        e.inst = i;
        e.rdata = rd_m[i];
        e.err  = err;
        e.due  = cap + ws_of[i];
        exp_q.push_back(e);
        addr[i]  = a;
        sdata[i] = d;
        mwr[i]   = wr;
        mrd[i]   = rd;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            if (rdy[i] === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (pert && cyc >= cap) begin
                addr[i]  = alt;
                sdata[i] = ~d;
            end
        end
        busy[i] = got;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout inst=%0d addr=%h: no MemReady within 40 cycles, required one at cyc %0d", i, a, e.due);
        end
    endtask

    task automatic release_req(input int i);
        mrd[i]  = 1'b0;
        mwr[i]  = 1'b0;
        busy[i] = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        bit          wr;
        int          i;
        int          other;
        Reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            addr[k] = '0; sdata[k] = '0; mrd[k] = 1'b0; mwr[k] = 1'b0;
            busy[k] = 1'b0; rd_m[k] = '0;
        end
        repeat (3) @(negedge CLK);
        Reset_n = 1'b1;

        // Reset state and quiet outputs
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            for (int j = 0; j < 2; j++) begin
                chk("reset_readdata", rdata[j], 64'd0);
                chk("reset_memready", 64'(rdy[j]), 64'd0);
            end
        end

        // Give every word a known value
        for (int j = 0; j < 2; j++) begin
            for (int w = 0; w < 64; w++)
                do_req(j, 1'b1, 1'b0, 64'(w) << 3, {$urandom, $urandom}, 1'b0, 64'd0);
            release_req(j);
        end

        // Store then load
        do_req(0, 1'b1, 1'b0, 64'h18, 64'hDEADBEEF_CAFEF00D, 1'b0, 64'd0);
        release_req(0);
        do_req(0, 1'b0, 1'b1, 64'h18, 64'd0, 1'b0, 64'd0);
        release_req(0);

        // Both request lines high is a store; address change mid-flight ignored
        do_req(0, 1'b1, 1'b1, 64'h20, 64'h5, 1'b1, 64'h28);
        release_req(0);
        do_req(0, 1'b0, 1'b1, 64'h20, 64'd0, 1'b0, 64'd0);
        release_req(0);
        do_req(0, 1'b0, 1'b1, 64'h28, 64'd0, 1'b0, 64'd0);
        release_req(0);

        // Wrap / bounds
        do_req(0, 1'b1, 1'b0, 64'h200, 64'h77, 1'b0, 64'd0);
        release_req(0);
        do_req(0, 1'b0, 1'b1, 64'h0, 64'd0, 1'b0, 64'd0);
        release_req(0);
        do_req(0, 1'b0, 1'b1, 64'h3, 64'd0, 1'b0, 64'd0);
        release_req(0);

        // Reset during WAIT aborts the store
        addr[0] = 64'h8; sdata[0] = 64'h99; mwr[0] = 1'b1;
        @(negedge CLK);
        Reset_n = 1'b0;
        mwr[0]  = 1'b0;
        @(negedge CLK);
        Reset_n = 1'b1;
        rd_m[0] = '0; rd_m[1] = '0; busy[0] = 1'b0; busy[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk("abort_no_ready", 64'(rdy[0]), 64'd0);
        end
        chk("abort_readdata_cleared", rdata[0], 64'd0);
        do_req(0, 1'b0, 1'b1, 64'h8, 64'd0, 1'b0, 64'd0);
        release_req(0);

        // Zero wait states, back-to-back loads
        do_req(1, 1'b0, 1'b1, 64'h0, 64'd0, 1'b0, 64'd0);
        do_req(1, 1'b0, 1'b1, 64'h8, 64'd0, 1'b0, 64'd0);
        release_req(1);

        // Randomized traffic, one instance active at a time
        for (int n = 0; n < 300; n++) begin
            i     = int'($urandom_range(0, 1));
            other = 1 - i;
            if (busy[other]) release_req(other);
            wr = 1'($urandom_range(0, 1));
            do_req(i, wr, wr ? 1'($urandom_range(0, 1)) : 1'b1, rand_addr(),
                   {$urandom, $urandom}, 1'($urandom_range(0, 1)), rand_addr());
            if ($urandom_range(0, 1) == 0) release_req(i);
        end
        if (busy[0]) release_req(0);
        if (busy[1]) release_req(1);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge CLK);
        chk("drain_outstanding", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
